// File: rtl/bus_txn_arbiter_if.sv
// Bus bundle between the two CPU cache controllers, the snoop/invalidate
// inputs of each cache, and the arbiter that sequences shared-bus transactions.
interface bus_txn_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              req_0;
  logic              req_1;
  logic [1:0]        op_0;
  logic [1:0]        op_1;
  logic [ADDR_W-1:0] addr_0;
  logic [ADDR_W-1:0] addr_1;
  logic              snoop_hit;
  logic              dmem_rdy;

  logic              grant_0;
  logic              grant_1;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              snoop_req;
  logic              inv_other;
  logic [1:0]        src_sel;
  logic              done_0;
  logic              done_1;
  logic              timeout_err;
  logic              op_err;
  logic              busy;

  modport slave (
    input  req_0, req_1, op_0, op_1, addr_0, addr_1, snoop_hit, dmem_rdy,
    output grant_0, grant_1, bus_op, bus_addr, snoop_req, inv_other,
           src_sel, done_0, done_1, timeout_err, op_err, busy
  );

  modport master (
    output req_0, req_1, op_0, op_1, addr_0, addr_1, snoop_hit, dmem_rdy,
    input  grant_0, grant_1, bus_op, bus_addr, snoop_req, inv_other,
           src_sel, done_0, done_1, timeout_err, op_err, busy
  );
endinterface

// File: rtl/bus_txn_arbiter.sv
// Round-robin arbiter for the shared snooping bus between cpu0 and cpu1; it
// walks the owner's transaction through snoop, invalidate and transfer phases.
module bus_txn_arbiter #(
  parameter int XFER_CYCLES = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int ADDR_W      = 13
) (
  input logic              clk,
  input logic              rst,
  bus_txn_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    INV,
    XFER_PROC,
    XFER_MEM,
    DONE
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;
  localparam logic [7:0] XFER_LAST = 8'(XFER_CYCLES - 1);
  localparam logic [7:0] MEM_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t            r_state;
  logic              r_owner;
  logic              r_last_owner;
  logic [1:0]        r_op_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [7:0]        r_cnt;
  logic              r_grant_0;
  logic              r_grant_1;
  logic              r_snoop_req;
  logic              r_inv_other;
  logic [1:0]        r_src_sel;
  logic              r_done_0;
  logic              r_done_1;
  logic              r_timeout_err;
  logic              r_op_err;
  logic              r_busy;

  logic              w_any_req;
  logic              w_winner;
  logic [1:0]        w_op;
  logic [ADDR_W-1:0] w_addr;

  // On a tie the CPU that did not own the bus last time wins.
  assign w_any_req = bus.req_0 | bus.req_1;
  assign w_winner  = (bus.req_0 & bus.req_1) ? ~r_last_owner : bus.req_1;
  assign w_op      = w_winner ? bus.op_1   : bus.op_0;
  assign w_addr    = w_winner ? bus.addr_1 : bus.addr_0;

  // Every transition also loads the outputs belonging to the state being
  // entered, so all outputs are registered yet line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_last_owner  <= 1'b1;
      r_op_q        <= 2'b00;
      r_addr_q      <= '0;
      r_cnt         <= 8'd0;
      r_grant_0     <= 1'b0;
      r_grant_1     <= 1'b0;
      r_snoop_req   <= 1'b0;
      r_inv_other   <= 1'b0;
      r_src_sel     <= 2'b00;
      r_done_0      <= 1'b0;
      r_done_1      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_op_err      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_snoop_req   <= 1'b0;
      r_inv_other   <= 1'b0;
      r_src_sel     <= 2'b00;
      r_done_0      <= 1'b0;
      r_done_1      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_op_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_op_q       <= w_op;
            r_addr_q     <= w_addr;
            r_cnt        <= 8'd0;
            r_grant_0    <= ~w_winner;
            r_grant_1    <= w_winner;
            r_busy       <= 1'b1;
            case (w_op)
              OP_READ, OP_WRITE: begin
                r_state     <= SNOOP;
                r_snoop_req <= 1'b1;
              end
              OP_INV: begin
                r_state     <= INV;
                r_inv_other <= 1'b1;
              end
              default: begin
                r_state  <= DONE;
                r_op_err <= 1'b1;
                r_done_0 <= ~w_winner;
                r_done_1 <= w_winner;
              end
            endcase
          end
        end
        SNOOP: begin
          if (r_op_q == OP_WRITE) begin
            r_state     <= INV;
            r_inv_other <= 1'b1;
          end else if (bus.snoop_hit) begin
            r_state   <= XFER_PROC;
            r_src_sel <= 2'b01;
            r_cnt     <= 8'd0;
          end else begin
            r_state <= XFER_MEM;
            r_cnt   <= 8'd0;
          end
        end
        INV: begin
          if (r_op_q == OP_WRITE) begin
            r_state <= XFER_MEM;
            r_cnt   <= 8'd0;
          end else begin
            r_state  <= DONE;
            r_done_0 <= ~r_owner;
            r_done_1 <= r_owner;
          end
        end
        XFER_PROC: begin
          if (r_cnt == XFER_LAST) begin
            r_state  <= DONE;
            r_done_0 <= ~r_owner;
            r_done_1 <= r_owner;
          end else begin
            r_cnt     <= r_cnt + 8'd1;
            r_src_sel <= 2'b01;
          end
        end
        // dmem_rdy on the final allowed cycle still wins over the timeout.
        XFER_MEM: begin
          if (bus.dmem_rdy || (r_cnt == MEM_LAST)) begin
            r_state       <= DONE;
            r_done_0      <= ~r_owner;
            r_done_1      <= r_owner;
            r_timeout_err <= ~bus.dmem_rdy;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_grant_0 <= 1'b0;
          r_grant_1 <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_grant_0 <= 1'b0;
          r_grant_1 <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_0     = r_grant_0;
  assign bus.grant_1     = r_grant_1;
  assign bus.bus_op      = r_op_q;
  assign bus.bus_addr    = r_addr_q;
  assign bus.snoop_req   = r_snoop_req;
  assign bus.inv_other   = r_inv_other;
  assign bus.src_sel     = r_src_sel;
  assign bus.done_0      = r_done_0;
  assign bus.done_1      = r_done_1;
  assign bus.timeout_err = r_timeout_err;
  assign bus.op_err      = r_op_err;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_bus_txn_arbiter.sv
// Self-checking bench for bus_txn_arbiter: directed cases plus random request
// patterns compared cycle by cycle with a phase-list reference model.
module tb_bus_txn_arbiter;
  localparam int XFER_CYCLES = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int ADDR_W      = 13;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bus_txn_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  bus_txn_arbiter #(
    .XFER_CYCLES(XFER_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // One entry per granted cycle: which phase the owner's transaction is in.
  typedef struct packed {
    logic snp;
    logic inv;
    logic pro;
    logic mem;
    logic rdy;
    logic dn;
    logic te;
    logic oe;
  } exp_t;

  exp_t              trace[$];
  int                testsRun  = 0;
  int                failCount = 0;
  logic              lastOwner;
  logic [1:0]        pOp[2];
  logic [ADDR_W-1:0] pAddr[2];
  logic              pHit[2];
  int                pDly[2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] obsCtl();
    return {21'd0, bus.grant_0, bus.grant_1, bus.busy, bus.snoop_req, bus.inv_other,
            bus.src_sel, bus.done_0, bus.done_1, bus.timeout_err, bus.op_err};
  endfunction

  function automatic logic [31:0] obsBus();
    return {17'd0, bus.bus_op, bus.bus_addr};
  endfunction

  function automatic logic [31:0] expCtl(input logic w, input exp_t e);
    return {21'd0, ~w, w, 1'b1, e.snp, e.inv, 1'b0, e.pro,
            e.dn & ~w, e.dn & w, e.te, e.oe};
  endfunction

  // dly is the XFER_MEM cycle (1-based) on which dmem answers.
  function automatic void buildTrace(input logic [1:0] op, input logic hit, input int dly);
    exp_t e;
    int   k;
    logic memPath;
    trace.delete();
    memPath = (op == 2'b01) || (op == 2'b00 && !hit);
    if (op != 2'b11) begin
      if (op != 2'b10) begin
        e = '0; e.snp = 1'b1; trace.push_back(e);
      end
      if (op != 2'b00) begin
        e = '0; e.inv = 1'b1; trace.push_back(e);
      end
      if (op == 2'b00 && hit) begin
        for (int i = 0; i < XFER_CYCLES; i++) begin
          e = '0; e.pro = 1'b1; trace.push_back(e);
        end
      end
      if (memPath) begin
        k = (dly < MEM_TIMEOUT) ? dly : MEM_TIMEOUT;
        for (int i = 1; i <= k; i++) begin
          e = '0; e.mem = 1'b1; e.rdy = (i == dly); trace.push_back(e);
        end
      end
    end
    e = '0;
    e.dn = 1'b1;
    e.oe = (op == 2'b11);
    e.te = memPath && (dly > MEM_TIMEOUT);
    trace.push_back(e);
  endfunction

  task automatic doReset();
    rst = 1'b1;
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    bus.op_0 = 2'b00; bus.op_1 = 2'b00;
    bus.addr_0 = '0; bus.addr_1 = '0;
    bus.snoop_hit = 1'b0; bus.dmem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstCtl", obsCtl(), 32'd0);
    checkOutput("rstBus", obsBus(), 32'd0);
    rst = 1'b0;
    lastOwner = 1'b1;
  endtask

  // Raise the requests in mask and serve them until neither is pending.
  task automatic applyStimulus(input logic [1:0] mask);
    logic pend[2];
    logic w;
    pend[0] = mask[0];
    pend[1] = mask[1];
    bus.req_0 = mask[0]; bus.op_0 = pOp[0]; bus.addr_0 = pAddr[0];
    bus.req_1 = mask[1]; bus.op_1 = pOp[1]; bus.addr_1 = pAddr[1];
    while (pend[0] || pend[1]) begin
      w = (pend[0] && pend[1]) ? ~lastOwner : pend[1];
      lastOwner = w;
      buildTrace(pOp[w], pHit[w], pDly[w]);
      @(posedge clk); #1;
      foreach (trace[c]) begin
        bus.snoop_hit = trace[c].snp ? pHit[w] : 1'($urandom);
        bus.dmem_rdy  = trace[c].mem ? trace[c].rdy : 1'($urandom);
        if (w) begin
          bus.op_1 = 2'($urandom); bus.addr_1 = ADDR_W'($urandom);
        end else begin
          bus.op_0 = 2'($urandom); bus.addr_0 = ADDR_W'($urandom);
        end
        @(negedge clk);
        checkOutput($sformatf("ctl cpu%0d c%0d", w, c), obsCtl(), expCtl(w, trace[c]));
        checkOutput($sformatf("busInfo cpu%0d c%0d", w, c), obsBus(), {17'd0, pOp[w], pAddr[w]});
        @(posedge clk); #1;
      end
      if (w) bus.req_1 = 1'b0;
      else   bus.req_0 = 1'b0;
      pend[w] = 1'b0;
      bus.snoop_hit = 1'b0;
      bus.dmem_rdy  = 1'b0;
      @(negedge clk);
      checkOutput("idleAfter", obsCtl(), 32'd0);
    end
  endtask

  task automatic setReq(input int cpu, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic hit, input int dly);
    pOp[cpu]   = op;
    pAddr[cpu] = addr;
    pHit[cpu]  = hit;
    pDly[cpu]  = dly;
  endtask

  initial begin
    exp_t pe;
    doReset();

    setReq(0, 2'b10, 13'h011, 1'b0, 1);
    setReq(1, 2'b10, 13'h122, 1'b0, 1);
    applyStimulus(2'b11);

    setReq(0, 2'b00, 13'h0A5, 1'b1, 1);
    applyStimulus(2'b01);

    setReq(1, 2'b00, 13'h1F0, 1'b0, 3);
    applyStimulus(2'b10);

    setReq(0, 2'b01, 13'h0C3, 1'b1, MEM_TIMEOUT + 5);
    applyStimulus(2'b01);

    setReq(1, 2'b01, 13'h0FF, 1'b0, MEM_TIMEOUT);
    applyStimulus(2'b10);

    setReq(1, 2'b11, 13'h1AB, 1'b0, 1);
    applyStimulus(2'b10);

    // Reset in the middle of a cache-to-cache transfer.
    setReq(0, 2'b00, 13'h1C3, 1'b1, 1);
    bus.req_0 = 1'b1; bus.op_0 = pOp[0]; bus.addr_0 = pAddr[0];
    @(posedge clk); #1;
    bus.snoop_hit = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    pe = '0; pe.pro = 1'b1;
    checkOutput("midProc", obsCtl(), expCtl(1'b0, pe));
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstCtl", obsCtl(), 32'd0);
    checkOutput("midRstBus", obsBus(), 32'd0);
    bus.req_0 = 1'b0;
    bus.snoop_hit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lastOwner = 1'b1;
    setReq(0, 2'b10, 13'h055, 1'b0, 1);
    setReq(1, 2'b00, 13'h066, 1'b1, 1);
    applyStimulus(2'b11);

    for (int n = 0; n < 40; n++) begin
      for (int cpu = 0; cpu < 2; cpu++) begin
        setReq(cpu, 2'($urandom), ADDR_W'($urandom), 1'($urandom),
               int'($urandom_range(1, MEM_TIMEOUT + 2)));
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        checkOutput("idleGap", obsCtl(), 32'd0);
      end
      applyStimulus(2'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
